// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// sitting between the Memory stage and a slower word-wide backing memory.
// Load hits return data combinationally in the same cycle. Load misses
// refill the whole line, one word per mem_ready_i. Stores are always
// written through to memory, and the cached copy is updated only on a hit.
// Optional macro DATA_CACHE_STATS_EN adds the hit_count_o/miss_count_o
// saturating counters.
//
// state  | meaning
// Idle   | serve load hits; decode misses and stores
// Refill | fetch line words 0..WORDS_PER_LINE-1 from backing memory
// Write  | write-through of the held store, waiting for mem_ready_i
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);

  localparam int offW = $clog2(WORDS_PER_LINE);
  localparam int idxW = $clog2(SETS);
  localparam int tagW = ADDR_WIDTH - 2 - offW - idxW;

  typedef enum logic [1:0] {Idle, Refill, Write} stateT;

  stateT                  state;
  logic [SETS-1:0]        validBits;
  logic [tagW-1:0]        tagArr  [SETS];
  logic [DATA_WIDTH-1:0]  dataArr [SETS*WORDS_PER_LINE];
  logic [offW-1:0]        refillCnt;
  logic [idxW-1:0]        lineIdx;
  logic [tagW-1:0]        lineTag;

  logic [offW-1:0]        cpuOff;
  logic [idxW-1:0]        cpuIdx;
  logic [tagW-1:0]        cpuTag;
  logic                   hit;
  logic                   loadHit;
  logic                   refillBeat;
  logic                   refillLast;
  logic                   writeDone;
  logic                   unusedAddrBits;

  assign cpuOff = addr_i[2 +: offW];
  assign cpuIdx = addr_i[2 + offW +: idxW];
  assign cpuTag = addr_i[ADDR_WIDTH-1 -: tagW];
  // Byte-within-word bits do not matter: every access is a full word.
  assign unusedAddrBits = ^addr_i[1:0];

  assign hit        = validBits[cpuIdx] && (tagArr[cpuIdx] == cpuTag);
  assign loadHit    = (state == Idle) && req_i && !we_i && hit;
  assign refillBeat = (state == Refill) && mem_ready_i;
  assign refillLast = refillBeat && (refillCnt == '1);
  assign writeDone  = (state == Write) && mem_ready_i;

  // CPU-side and memory-side outputs, decoded from state and the held request
  always_comb begin
    rdata_o     = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      Idle: begin
        if (loadHit) rdata_o = dataArr[{cpuIdx, cpuOff}];
        stall_o = req_i && (we_i || !hit);
      end
      Refill: begin
        stall_o    = req_i;
        mem_req_o  = 1'b1;
        mem_addr_o = {lineTag, lineIdx, refillCnt, 2'b00};
      end
      Write: begin
        stall_o     = req_i && !mem_ready_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

  // Controller: state, valid bits, refill counter and the latched line address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= Idle;
      validBits <= '0;
      refillCnt <= '0;
      lineIdx   <= '0;
      lineTag   <= '0;
    end else begin
      case (state)
        Idle: begin
          if (req_i) begin
            if (we_i) begin
              state <= Write;
            end else if (!hit) begin
              // Drop the victim's valid bit up front so a half-written line
              // can never look valid under its old tag.
              state             <= Refill;
              lineIdx           <= cpuIdx;
              lineTag           <= cpuTag;
              validBits[cpuIdx] <= 1'b0;
            end
          end
        end
        Refill: begin
          if (mem_ready_i) begin
            refillCnt <= refillCnt + 1'b1;
            if (refillLast) begin
              validBits[lineIdx] <= 1'b1;
              refillCnt          <= '0;
              state              <= Idle;
            end
          end
        end
        Write: begin
          if (mem_ready_i) state <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

  // Tag/data arrays: refill beats, refill completion and store-hit updates
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refillBeat) dataArr[{lineIdx, refillCnt}] <= mem_rdata_i;
      if (refillLast) tagArr[lineIdx] <= lineTag;
      if (writeDone && hit) dataArr[{cpuIdx, cpuOff}] <= wdata_i;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic loadMiss;
  assign loadMiss = (state == Idle) && req_i && !we_i && !hit;

  // Saturating hit/miss statistics; stores are not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (loadHit && (hit_count_o != '1)) hit_count_o <= hit_count_o + 1'b1;
      if (loadMiss && (miss_count_o != '1)) miss_count_o <= miss_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's Memory stage and a slower backing data memory.
- Acts as the responder to the core's load/store requests.
- Acts as the initiator of word-wide requests to backing memory, using a valid/ready handshake.
- Drives a stall back to the hazard unit while a miss refill or a write-through is outstanding.

Parameters:
- DATA_WIDTH, 32, word width of CPU and memory data.
- ADDR_WIDTH, 32, byte address width.
- SETS, 64, number of lines; power of two.
- WORDS_PER_LINE, 4, words per line; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  CPU access valid in Memory stage.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  ADDR_WIDTH  CPU byte address (ALUResultM).
- wdata_i  in  DATA_WIDTH  store data (WriteDataM).
- rdata_o  out  DATA_WIDTH  load data.
- stall_o  out  1  request not yet complete; pipeline must hold.
- mem_req_o  out  1  backing-memory request valid.
- mem_we_o  out  1  backing-memory write.
- mem_addr_o  out  ADDR_WIDTH  backing-memory word-aligned byte address.
- mem_wdata_o  out  DATA_WIDTH  backing-memory write data.
- mem_rdata_i  in  DATA_WIDTH  backing-memory read data, valid when mem_ready_i=1.
- mem_ready_i  in  1  backing memory accepts/completes the current request this cycle.

Behaviour:
- Clocking and reset: single clock clk_i; rst_i synchronous active-high.
- Reset state: after the reset edge, FSM=IDLE, all valid bits=0, refill counter=0. All outputs are 0 (rdata_o=0, stall_o=0, mem_req_o=0, mem_we_o=0). Tag/data arrays are not reset.
- Address split (defaults): [1:0] ignored (word access only); word offset [3:2]; index [9:4]; tag [31:10]. Widths derive from the parameters via $clog2.
- hit = valid[index] && tag match.
- IDLE:
  - Load hit: rdata_o is driven combinationally the same cycle; stall_o=0 (zero added latency).
  - Load miss: stall_o=1 combinationally; next state REFILL.
  - Store: stall_o=1; next state WRITE. The store is always written through.
  - req_i=0: stall_o=0, rdata_o=0, stay IDLE.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = line base + 4*counter.
  - On each cycle with mem_ready_i=1, mem_rdata_i is written to word[counter] of the line and counter increments.
  - When the last word is accepted, set valid[index]=1, update the tag, reset counter to 0, go to IDLE. stall_o stays 1 throughout.
  - The next cycle the held request hits and stall_o drops. Miss penalty = WORDS_PER_LINE ready cycles + 1.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = {addr_i[ADDR_WIDTH-1:2],2'b00}, mem_wdata_o=wdata_i.
  - In the cycle mem_ready_i=1:
    - If hit, write the cached word.
    - stall_o=0 combinationally (store retires this edge).
    - Go to IDLE.
  - On a miss, the line is not allocated and valid is unchanged.
- mem_req_o, mem_we_o and mem_addr_o are functions of state and counter plus latched/held CPU inputs. They must stay stable while mem_req_o=1 and mem_ready_i=0.
- The CPU holds req_i, we_i, addr_i and wdata_i stable while stall_o=1.
- If req_i drops during REFILL, the refill still completes and the line becomes valid; stall_o=0 whenever req_i=0.
- mem_ready_i is ignored in IDLE.
- Reset mid-REFILL or mid-WRITE: the operation is abandoned; mem_req_o=0 after the reset edge; the partially filled line stays invalid (all valid cleared).
- Address aliasing: a store hit updates cache and memory. A store miss followed by a load of the same address refills from memory and returns the stored value.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- When defined: adds outputs hit_count_o and miss_count_o, each 32 bits, as saturating counters, both reset to 0.
  - A load hit increments hit_count_o once per completed access (the IDLE cycle with stall_o=0), including the post-refill hit.
  - A load miss increments miss_count_o once, on entry to REFILL.
  - Stores count as neither.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x0000_0100 with memory words 0x100..0x10C = 0x11,0x22,0x33,0x44 and mem_ready_i always 1 -> stall_o high for 5 cycles, mem_addr_o walks 0x100,0x104,0x108,0x10C, then rdata_o=0x11 with stall_o=0.
- Next load 0x0000_0108 -> rdata_o=0x33 in the same cycle, stall_o=0, mem_req_o=0.
- Store 0xDEADBEEF to 0x104 (hit) with mem_ready_i delayed 3 cycles -> mem_req_o/mem_we_o held with stable address and data; stall_o drops in the ready cycle; a following load of 0x104 returns 0xDEADBEEF with no refill.
- Load 0x0000_0500 (same index as 0x100, different tag) -> miss, refill from 0x500, old line evicted; a subsequent load of 0x100 misses again.
- Assert rst_i on the second refill beat -> mem_req_o=0 next cycle, FSM=IDLE; re-issuing the load performs a full 4-beat refill.
- With DATA_CACHE_STATS_EN, run the first two scenarios -> miss_count_o=1, hit_count_o=2.
